activation: RTL and testbench
=============================

# activation

Parametrised fixed-point activation unit for the trainable neuron datapath, generalising the step unit to selectable STEP, RELU and LINSAT modes with configurable widths. Forward: streams arguments to results. In training mode (`en`), each transfer queues its derivative gate in a DEPTH-entry FIFO, so up to DEPTH forward results can be outstanding. Backward: errors are then gated in order into feedback.

## Interface
- ARGW, 16, signed argument width
- ARGF, 8, argument fraction bits; constraint RESW <= ARGF < ARGW
- RESW, 8, unsigned result width; all-ones = 1.0
- ERRW, 16, signed error width
- FBKW, 16, signed feedback width; constraint FBKW >= ERRW
- DEPTH, 4, gate FIFO entries (power of two, >= 2)
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- en  in  1  training mode, sampled on each arg transfer
- mode  in  2  0 STEP, 1 RELU, 2 LINSAT, 3 reserved (= STEP); sampled on each arg transfer
- arg_data/arg_valid/arg_ready  in/in/out  ARGW/1/1  argument stream
- res_data/res_valid/res_ready  out/out/in  RESW/1/1  result stream
- err_data/err_valid/err_ready  in/in/out  ERRW/1/1  error stream
- fbk_data/fbk_valid/fbk_ready  out/out/in  FBKW/1/1  feedback stream

## Operation
- Transfer = valid & ready on the same rising edge.
- Forward, with a = arg and ONE = 2^ARGF:
  - STEP: res = (a >= 0) ? all-ones : 0; gate PASS.
  - RELU: u = a. LINSAT: u = (a >>> 1) + ONE/2, computed at ARGW+1 bits.
  - For RELU/LINSAT: res = 0 if u <= 0; all-ones if u >= ONE; else u[ARGF-1 -: RESW] (truncation).
  - RELU gate = PASS if a > 0, else ZERO. LINSAT gate = HALF if 0 < u < ONE, else ZERO.
- Gate FIFO: an arg transfer with en=1 pushes the gate (2-bit gate_t). With en=0 nothing is pushed.
- Backward: an err transfer pops one gate. err is sign-extended to FBKW, then:
  - PASS: fbk = err.
  - HALF: fbk = err >>> 1 (rounds toward -inf, so -1 -> -1).
  - ZERO: fbk = 0.
- Ordering: feedback strictly follows arg-push order.
- Changing mode/en with entries pending does not alter queued gates.
- The err stream is independent of en; pending entries are always drainable.

## Timing
- Reset values: res_valid=0, fbk_valid=0, res_data=0, fbk_data=0, FIFO empty, so err_ready=0 and arg_ready=1.
- Forward latency: 1 cycle, registered output stage.
- arg_ready = (!res_valid | res_ready) & !(en & full). This is combinational from state, en and res_ready; it never depends on arg_valid.
- err_ready = !empty & (!fbk_valid | fbk_ready). Feedback latency: 1 cycle.
- Full throughput: one arg and one err per cycle each, simultaneously, including push and pop on the same edge.
- Full FIFO with en=1: arg_ready=0 even if a pop occurs that cycle (no bypass).
- Output data holds stable while valid & !ready.
- rst asserted mid-operation: immediately clears valids and the FIFO, discarding pending gates.

## Configuration
- ACTIVATION_LINSAT_EN defined: LINSAT mode implemented as above.
- Undefined: mode 2 behaves exactly as STEP (output and gate PASS); no LINSAT adder logic is synthesised.

## Structure
- activation_pkg: mode_t enum (STEP, RELU, LINSAT), gate_t enum (ZERO, PASS, HALF), and the mode/gate width constants.
- Sub-module gate_fifo:
  - parameters DEPTH and width;
  - signals push, pop, full, empty, data;
  - async active-high reset.
- Top level: forward datapath plus the two output registers.

## Test plan
Defaults ARGW=16, ARGF=8, RESW=8, DEPTH=4; ACTIVATION_LINSAT_EN defined unless stated.
- STEP, en=0: arg 0x0000 -> res 0xff; arg 0xffff -> res 0x00; err_ready stays 0.
- STEP, en=1: arg 0xffff -> res 0x00; err 0xffff -> fbk 0xffff (-1).
- RELU, en=1: args 0x0080, 0xff80, 0x0200 -> res 0x80, 0x00, 0xff. Then errs 0x0100 x3 -> fbk 0x0100, 0x0000, 0x0100 in order.
- LINSAT, en=1: arg 0x0000 -> res 0x80, and err 0x0010 -> fbk 0x0008. arg 0x0300 -> res 0xff, and err 0x0010 -> fbk 0x0000. Without the macro, arg 0x0000 in mode 2 -> res 0xff.
- Full FIFO: en=1, 4 args with no errs -> arg_ready=0 on the 5th; one err transfer -> arg_ready=1 the next cycle.
- Backpressure/reset: res_ready=0 for 10 cycles holds res_data/res_valid stable. Assert rst with 3 gates pending -> err_ready=0, res_valid=0, fbk_valid=0 immediately, and the STEP test passes after reset.

Source files
------------

// File: rtl/activation_pkg.sv
// Shared types for the activation unit: activation modes, derivative gates,
// and the widths of the mode and gate fields.
// Pure declarations; no logic.
package activation_pkg;

   localparam int MODE_W = 2;
   localparam int GATE_W = 2;

   // Encoding 3 is reserved and decodes as STEP.
   typedef enum logic [MODE_W-1:0] {
      MODE_STEP   = 2'd0,
      MODE_RELU   = 2'd1,
      MODE_LINSAT = 2'd2
   } mode_t;

   // Derivative gate applied to the matching backward error.
   typedef enum logic [GATE_W-1:0] {
      GATE_ZERO = 2'd0,
      GATE_PASS = 2'd1,
      GATE_HALF = 2'd2
   } gate_t;

endpackage

// File: rtl/activation_gate_fifo.sv
// Gate FIFO: holds derivative gates between forward pushes and backward pops.
// Latency: a pushed entry can be popped on the edge after the push.
// Backpressure: the caller must not push when full or pop when empty.
//
// Ports: clk, rst (async, active-high), push/push_data write one entry,
// pop removes the head entry, pop_data shows the head, full/empty report occupancy.
module activation_gate_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);

endmodule

// File: rtl/activation.sv
// Fixed-point activation unit (STEP/RELU/LINSAT) with an in-order derivative-gate FIFO for training.
// Latency: 1 cycle arg->res and 1 cycle err->fbk, both through registered output stages.
// Backpressure: arg stalls on a held result or a full gate FIFO in training mode; err stalls on an empty FIFO or a held feedback.
//
// Ports: clk, rst (async, active-high); en = training mode, mode = activation select,
// both sampled on each arg transfer; arg/res forward stream; err/fbk backward stream.
// Optional feature: define ACTIVATION_LINSAT_EN to implement LINSAT; otherwise mode 2 acts as STEP.
module activation #(
   parameter int ARGW  = 16,
   parameter int ARGF  = 8,
   parameter int RESW  = 8,
   parameter int ERRW  = 16,
   parameter int FBKW  = 16,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [1:0]      mode,
   input  logic [ARGW-1:0] arg_data,
   input  logic            arg_valid,
   output logic            arg_ready,
   output logic [RESW-1:0] res_data,
   output logic            res_valid,
   input  logic            res_ready,
   input  logic [ERRW-1:0] err_data,
   input  logic            err_valid,
   output logic            err_ready,
   output logic [FBKW-1:0] fbk_data,
   output logic            fbk_valid,
   input  logic            fbk_ready
);

   import activation_pkg::*;

   // 1.0 in the argument format, held one bit wider than the argument.
   localparam logic signed [ARGW:0] ONE = {{(ARGW-ARGF){1'b0}}, 1'b1, {ARGF{1'b0}}};
`ifdef ACTIVATION_LINSAT_EN
   localparam logic signed [ARGW:0] HALF = ONE >>> 1;
`endif

   logic                   full, empty;
   logic                   arg_xfer, err_xfer;
   logic [GATE_W-1:0]      head_bits;
   gate_t                  head_gate;
   gate_t                  gate_calc;
   logic [RESW-1:0]        res_calc;
   logic signed [ARGW:0]   a_ext, u;
   logic                   linear;
   logic signed [FBKW-1:0] err_ext, fbk_calc;

   logic            res_valid_q, res_valid_d;
   logic [RESW-1:0] res_data_q, res_data_d;
   logic            fbk_valid_q, fbk_valid_d;
   logic [FBKW-1:0] fbk_data_q, fbk_data_d;

   // No pop bypass: a full FIFO blocks training-mode args even when popping.
   assign arg_ready = (!res_valid_q || res_ready) && !(en && full);
   assign err_ready = !empty && (!fbk_valid_q || fbk_ready);
   assign arg_xfer  = arg_valid && arg_ready;
   assign err_xfer  = err_valid && err_ready;

   // Forward function and derivative gate.
   always_comb begin
      a_ext     = {arg_data[ARGW-1], arg_data};
      u         = a_ext;
      linear    = 1'b0;
      res_calc  = '0;
      gate_calc = GATE_PASS;
      case (mode)
         MODE_RELU: linear = 1'b1;
`ifdef ACTIVATION_LINSAT_EN
         MODE_LINSAT: begin
            linear = 1'b1;
            u      = (a_ext >>> 1) + HALF;
         end
`endif
         default: linear = 1'b0;
      endcase

      if (!linear) begin
         res_calc = a_ext[ARGW] ? '0 : '1;
      end else if (u[ARGW] || (u == '0)) begin
         res_calc  = '0;
         gate_calc = GATE_ZERO;
      end else if (u >= ONE) begin
         // Saturated: RELU still has slope 1 here, LINSAT is flat.
         res_calc  = '1;
         gate_calc = (mode == MODE_RELU) ? GATE_PASS : GATE_ZERO;
      end else begin
         res_calc  = u[ARGF-1 -: RESW];
         gate_calc = (mode == MODE_RELU) ? GATE_PASS : GATE_HALF;
      end
   end

   activation_gate_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (GATE_W)
   ) u_gate_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (arg_xfer && en),
      .push_data (gate_calc),
      .pop       (err_xfer),
      .pop_data  (head_bits),
      .full      (full),
      .empty     (empty)
   );

   assign head_gate = gate_t'(head_bits);

   // Backward gating; the arithmetic shift gives HALF its round-toward-minus-infinity.
   always_comb begin
      err_ext = FBKW'($signed(err_data));
      case (head_gate)
         GATE_PASS: fbk_calc = err_ext;
         GATE_HALF: fbk_calc = err_ext >>> 1;
         default:   fbk_calc = '0;
      endcase
   end

   // Output stages: load on transfer, clear on consumer acceptance, otherwise hold.
   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      fbk_valid_d = fbk_valid_q;
      fbk_data_d  = fbk_data_q;
      if (arg_xfer) begin
         res_valid_d = 1'b1;
         res_data_d  = res_calc;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
      if (err_xfer) begin
         fbk_valid_d = 1'b1;
         fbk_data_d  = fbk_calc;
      end else if (fbk_ready) begin
         fbk_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         fbk_valid_q <= 1'b0;
         fbk_data_q  <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         fbk_valid_q <= fbk_valid_d;
         fbk_data_q  <= fbk_data_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign fbk_valid = fbk_valid_q;
   assign fbk_data  = fbk_data_q;

endmodule

// File: tb/tb_activation.sv
// Testbench for activation: directed scenarios plus a randomized stream
// checked against an arithmetic reference model with queue scoreboards.
// Follows ACTIVATION_LINSAT_EN if it is defined for the build.
module tb_activation;

   localparam int ARGW  = 16;
   localparam int ARGF  = 8;
   localparam int RESW  = 8;
   localparam int ERRW  = 16;
   localparam int FBKW  = 16;
   localparam int DEPTH = 4;
`ifdef ACTIVATION_LINSAT_EN
   localparam bit LINSAT_ON = 1'b1;
`else
   localparam bit LINSAT_ON = 1'b0;
`endif

   logic            clk;
   logic            rst;
   logic            en;
   logic [1:0]      mode;
   logic [ARGW-1:0] arg_data;
   logic            arg_valid;
   logic            arg_ready;
   logic [RESW-1:0] res_data;
   logic            res_valid;
   logic            res_ready;
   logic [ERRW-1:0] err_data;
   logic            err_valid;
   logic            err_ready;
   logic [FBKW-1:0] fbk_data;
   logic            fbk_valid;
   logic            fbk_ready;

   int checks = 0;
   int errors = 0;

   activation #(
      .ARGW(ARGW), .ARGF(ARGF), .RESW(RESW), .ERRW(ERRW), .FBKW(FBKW), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .arg_data(arg_data), .arg_valid(arg_valid), .arg_ready(arg_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .err_data(err_data), .err_valid(err_valid), .err_ready(err_ready),
      .fbk_data(fbk_data), .fbk_valid(fbk_valid), .fbk_ready(fbk_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: the activation as a real-valued function on integers.
   // factor is the derivative in halves (2 = pass, 1 = half, 0 = zero).
   function automatic int model_res(input logic [ARGW-1:0] d, input logic [1:0] m, output int factor);
      int a, u, r;
      a = int'($signed(d));
      factor = 2;
      if (m == 2'd1 || (m == 2'd2 && LINSAT_ON)) begin
         if (m == 2'd1) u = a;
         else           u = (a >>> 1) + (1 << (ARGF-1));
         if (u <= 0)                r = 0;
         else if (u >= (1 << ARGF)) r = (1 << RESW) - 1;
         else                       r = u >>> (ARGF - RESW);
         if (m == 2'd1) factor = (a > 0) ? 2 : 0;
         else           factor = (u > 0 && u < (1 << ARGF)) ? 1 : 0;
      end else begin
         r = (a >= 0) ? (1 << RESW) - 1 : 0;
      end
      return r;
   endfunction

   function automatic int model_fbk(input logic [ERRW-1:0] e, input int factor);
      int v;
      v = int'($signed(e)) * factor;
      return v >>> 1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      arg_valid = 1'b0; err_valid = 1'b0;
      res_ready = 1'b1; fbk_ready = 1'b1;
      en = 1'b0; mode = 2'd0; arg_data = '0; err_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
   endtask

   // Presents one arg, waits (bounded) for acceptance, returns just after the next falling edge.
   task automatic send_arg(input logic [ARGW-1:0] a, input logic [1:0] m, input logic e);
      int n;
      arg_data = a; mode = m; en = e; arg_valid = 1'b1; n = 0;
      #1;
      while (!arg_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (arg_ready !== 1'b1) begin
         errors++;
         $display("FAIL arg_handshake_timeout: arg_ready=%b required 1", arg_ready);
      end
      @(posedge clk);
      @(negedge clk);
      arg_valid = 1'b0;
      #1;
   endtask

   task automatic send_err(input logic [ERRW-1:0] e);
      int n;
      err_data = e; err_valid = 1'b1; n = 0;
      #1;
      while (!err_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (err_ready !== 1'b1) begin
         errors++;
         $display("FAIL err_handshake_timeout: err_ready=%b required 1", err_ready);
      end
      @(posedge clk);
      @(negedge clk);
      err_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      checks++; if (fbk_valid !== 1'b0) begin errors++; $display("FAIL reset_fbk_valid: got %b want 0", fbk_valid); end
      checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data: got %h want 00", res_data); end
      checks++; if (fbk_data !== 16'h0000) begin errors++; $display("FAIL reset_fbk_data: got %h want 0000", fbk_data); end
      checks++; if (err_ready !== 1'b0) begin errors++; $display("FAIL reset_err_ready: got %b want 0", err_ready); end
      en = 1'b1; #1;
      checks++; if (arg_ready !== 1'b1) begin errors++; $display("FAIL reset_arg_ready: got %b want 1", arg_ready); end
      en = 1'b0;
   endtask

   task automatic test_step_noen();
      send_arg(16'h0000, 2'd0, 1'b0);
      checks++; if (res_valid !== 1'b1 || res_data !== 8'hff) begin errors++; $display("FAIL step_zero: got v=%b %h want v=1 ff", res_valid, res_data); end
      send_arg(16'hffff, 2'd0, 1'b0);
      checks++; if (res_valid !== 1'b1 || res_data !== 8'h00) begin errors++; $display("FAIL step_neg: got v=%b %h want v=1 00", res_valid, res_data); end
      checks++; if (err_ready !== 1'b0) begin errors++; $display("FAIL step_noen_err_ready: got %b want 0", err_ready); end
   endtask

   task automatic test_step_en();
      checks++; if (err_ready !== 1'b0) begin errors++; $display("FAIL step_en_fifo_empty: err_ready=%b want 0", err_ready); end
      send_arg(16'hffff, 2'd0, 1'b1);
      checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL step_en_res: got %h want 00", res_data); end
      send_err(16'hffff);
      checks++; if (fbk_valid !== 1'b1 || fbk_data !== 16'hffff) begin errors++; $display("FAIL step_en_fbk: got v=%b %h want v=1 ffff", fbk_valid, fbk_data); end
   endtask

   task automatic test_relu();
      logic [ARGW-1:0] args [3];
      logic [RESW-1:0] exp_res [3];
      logic [FBKW-1:0] exp_fbk [3];
      args    = '{16'h0080, 16'hff80, 16'h0200};
      exp_res = '{8'h80, 8'h00, 8'hff};
      exp_fbk = '{16'h0100, 16'h0000, 16'h0100};
      for (int i = 0; i < 3; i++) begin
         send_arg(args[i], 2'd1, 1'b1);
         checks++; if (res_data !== exp_res[i]) begin errors++; $display("FAIL relu_res[%0d]: got %h want %h", i, res_data, exp_res[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         send_err(16'h0100);
         checks++; if (fbk_data !== exp_fbk[i]) begin errors++; $display("FAIL relu_fbk[%0d]: got %h want %h", i, fbk_data, exp_fbk[i]); end
      end
   endtask

   task automatic test_linsat();
      logic [RESW-1:0] er;
      logic [FBKW-1:0] ef;
      er = LINSAT_ON ? 8'h80 : 8'hff;
      ef = LINSAT_ON ? 16'h0008 : 16'h0010;
      send_arg(16'h0000, 2'd2, 1'b1);
      checks++; if (res_data !== er) begin errors++; $display("FAIL linsat_mid_res: got %h want %h", res_data, er); end
      send_err(16'h0010);
      checks++; if (fbk_data !== ef) begin errors++; $display("FAIL linsat_mid_fbk: got %h want %h", fbk_data, ef); end
      ef = LINSAT_ON ? 16'h0000 : 16'h0010;
      send_arg(16'h0300, 2'd2, 1'b1);
      checks++; if (res_data !== 8'hff) begin errors++; $display("FAIL linsat_sat_res: got %h want ff", res_data); end
      send_err(16'h0010);
      checks++; if (fbk_data !== ef) begin errors++; $display("FAIL linsat_sat_fbk: got %h want %h", fbk_data, ef); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_arg(16'h0100, 2'd1, 1'b1);
      arg_data = 16'h0040; mode = 2'd1; en = 1'b1; arg_valid = 1'b1;
      err_data = 16'h0005; err_valid = 1'b1;
      #1;
      checks++; if (arg_ready !== 1'b0) begin errors++; $display("FAIL full_arg_ready: got %b want 0", arg_ready); end
      checks++; if (err_ready !== 1'b1) begin errors++; $display("FAIL full_err_ready: got %b want 1", err_ready); end
      @(posedge clk);
      @(negedge clk);
      arg_valid = 1'b0; err_valid = 1'b0;
      #1;
      checks++; if (arg_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: arg_ready=%b want 1", arg_ready); end
      checks++; if (fbk_data !== 16'h0005) begin errors++; $display("FAIL full_fbk: got %h want 0005", fbk_data); end
   endtask

   task automatic test_backpressure();
      do_reset();
      res_ready = 1'b0;
      send_arg(16'h0080, 2'd1, 1'b0);
      arg_data = 16'h7fff; arg_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         checks++;
         if (res_valid !== 1'b1 || res_data !== 8'h80 || arg_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got v=%b %h ardy=%b want v=1 80 ardy=0", i, res_valid, res_data, arg_ready);
         end
      end
      arg_valid = 1'b0; res_ready = 1'b1;
      @(negedge clk); #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_release: res_valid=%b want 0", res_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_arg(16'h0100, 2'd1, 1'b1);
      res_ready = 1'b0;
      fbk_ready = 1'b0;
      send_err(16'h0001);
      fbk_ready = 1'b1;
      #1;
      checks++; if (err_ready !== 1'b1 || res_valid !== 1'b1 || fbk_valid !== 1'b1) begin
         errors++; $display("FAIL pre_reset: erdy=%b rv=%b fv=%b want 1 1 1", err_ready, res_valid, fbk_valid);
      end
      rst = 1'b1;
      #1;
      checks++; if (err_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_err_ready: got %b want 0", err_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_res_valid: got %b want 0", res_valid); end
      checks++; if (fbk_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_fbk_valid: got %b want 0", fbk_valid); end
      repeat (2) @(negedge clk);
      rst = 1'b0; res_ready = 1'b1;
      @(negedge clk); #1;
      test_step_noen();
      test_step_en();
   endtask

   task automatic test_random();
      int res_q[$];
      int gate_q[$];
      int fbk_q[$];
      int r, f, v;
      bit exp_ardy, exp_erdy;
      logic [RESW-1:0] er;
      logic [FBKW-1:0] ef;
      do_reset();
      for (int cyc = 0; cyc < 700; cyc++) begin
         @(negedge clk);
         if (cyc < 600) begin
            arg_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
               0: arg_data = ARGW'($urandom);
               1: arg_data = ARGW'($urandom_range(0, 16'h0300));
               2: arg_data = 16'hffff - ARGW'($urandom_range(0, 16'h0300));
               default: arg_data = ($urandom_range(0, 1) != 0) ? 16'h0100 : 16'hfe00;
            endcase
            mode      = 2'($urandom_range(0, 3));
            en        = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            err_valid = ($urandom_range(0, 2) != 0);
            err_data  = ERRW'($urandom);
            fbk_ready = ($urandom_range(0, 2) != 0);
         end else begin
            arg_valid = 1'b0; res_ready = 1'b1;
            err_valid = 1'b1; fbk_ready = 1'b1;
            err_data  = ERRW'($urandom);
         end
         #1;
         exp_ardy = (res_q.size() == 0 || res_ready) && !(en && gate_q.size() == DEPTH);
         exp_erdy = (gate_q.size() != 0) && (fbk_q.size() == 0 || fbk_ready);
         checks++; if (res_valid !== (res_q.size() != 0)) begin errors++; $display("FAIL rnd_res_valid@%0d: got %b want %0d", cyc, res_valid, res_q.size() != 0); end
         checks++; if (fbk_valid !== (fbk_q.size() != 0)) begin errors++; $display("FAIL rnd_fbk_valid@%0d: got %b want %0d", cyc, fbk_valid, fbk_q.size() != 0); end
         checks++; if (arg_ready !== exp_ardy) begin errors++; $display("FAIL rnd_arg_ready@%0d: got %b want %b", cyc, arg_ready, exp_ardy); end
         checks++; if (err_ready !== exp_erdy) begin errors++; $display("FAIL rnd_err_ready@%0d: got %b want %b", cyc, err_ready, exp_erdy); end
         if (res_ready && res_q.size() != 0) begin
            r = res_q.pop_front();
            er = r[RESW-1:0];
            checks++; if (res_data !== er) begin errors++; $display("FAIL rnd_res_data@%0d: got %h want %h", cyc, res_data, er); end
         end
         if (fbk_ready && fbk_q.size() != 0) begin
            v = fbk_q.pop_front();
            ef = v[FBKW-1:0];
            checks++; if (fbk_data !== ef) begin errors++; $display("FAIL rnd_fbk_data@%0d: got %h want %h", cyc, fbk_data, ef); end
         end
         if (arg_valid && exp_ardy) begin
            r = model_res(arg_data, mode, f);
            res_q.push_back(r);
            if (en) gate_q.push_back(f);
         end
         if (err_valid && exp_erdy) begin
            f = gate_q.pop_front();
            fbk_q.push_back(model_fbk(err_data, f));
         end
      end
      err_valid = 1'b0;
      checks++; if (res_q.size() + gate_q.size() + fbk_q.size() != 0) begin
         errors++; $display("FAIL rnd_drain: res=%0d gates=%0d fbk=%0d outstanding, want 0", res_q.size(), gate_q.size(), fbk_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      arg_valid = 1'b0; err_valid = 1'b0;
      res_ready = 1'b1; fbk_ready = 1'b1;
      en = 1'b0; mode = 2'd0; arg_data = '0; err_data = '0;
      test_reset();
      test_step_noen();
      test_step_en();
      test_relu();
      test_linsat();
      test_full();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
